// File: rtl/data_mem_be_pkg.sv
// Shared encodings and lane helpers for the byte-enabled data memory.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_BAD  = 2'b11
    } size_e;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size_e'(size))
            SZ_BYTE: return 1'b0;
            SZ_HALF: return lane[0];
            SZ_WORD: return |lane;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
        case (size_e'(size))
            SZ_BYTE: return 4'b0001 << lane;
            SZ_HALF: return lane[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Right-justified store data replicated so every lane sees its own slice.
    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] d);
        case (size_e'(size))
            SZ_BYTE: return {4{d[7:0]}};
            SZ_HALF: return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_be_if.sv
// Load/store bus between a requester and data_mem_be.
interface data_mem_be_if #(
    parameter int ADDR_W = 32
);
    logic              re;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic              we;
    logic [ADDR_W-1:0] wr_addr;
    logic [1:0]        w_size;
    logic [31:0]       data_in;
    logic [31:0]       data_out;
    logic              r_valid;
    logic              r_err;
    logic              w_err;
    logic              busy;

    modport master (
        output re, r_addr, r_size, r_unsigned, we, wr_addr, w_size, data_in,
        input  data_out, r_valid, r_err, w_err, busy
    );

    modport slave (
        input  re, r_addr, r_size, r_unsigned, we, wr_addr, w_size, data_in,
        output data_out, r_valid, r_err, w_err, busy
    );
endinterface

// File: rtl/data_mem_be_load_align.sv
// Selects the addressed byte/half of a word and sign- or zero-extends it.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'(word >> {lane, 3'b000});
        half_sel = lane[1] ? word[31:16] : word[15:0];
        data     = '0;
        case (size_e'(size))
            SZ_BYTE: data = is_unsigned ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            SZ_HALF: data = is_unsigned ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            SZ_WORD: data = word;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_be.sv
// Byte-addressed data memory with byte/half/word access, 1-cycle loads and a
// post-reset sweep that zeroes every word before accepting requests.
module data_mem_be
    import dmem_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 32
) (
    input  logic           clk,
    input  logic           rst,
    data_mem_be_if.slave   bus
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int BYTE_W = IDX_W + 2;

    logic [31:0] mem [DEPTH];

    state_e           state, next_state;
    logic [IDX_W-1:0] count, next_count;
    logic             clear_we;
    logic             ready;

    logic             r_oor, w_oor;
    logic             r_error, w_error;
    logic [IDX_W-1:0] r_idx, w_idx;
    logic [31:0]      r_word, aligned;

    logic             store_we, mem_we;
    logic [IDX_W-1:0] mem_idx;
    logic [3:0]       mem_mask;
    logic [31:0]      mem_wdata;

    generate
        if (ADDR_W > BYTE_W) begin : g_range
            assign r_oor = |bus.r_addr[ADDR_W-1:BYTE_W];
            assign w_oor = |bus.wr_addr[ADDR_W-1:BYTE_W];
        end else begin : g_no_range
            assign r_oor = 1'b0;
            assign w_oor = 1'b0;
        end
    endgenerate

    assign r_idx   = bus.r_addr[BYTE_W-1:2];
    assign w_idx   = bus.wr_addr[BYTE_W-1:2];
    assign r_error = r_oor | misaligned(bus.r_size, bus.r_addr[1:0]);
    assign w_error = w_oor | misaligned(bus.w_size, bus.wr_addr[1:0]);

    assign ready    = (state == ST_READY);
    assign bus.busy = (state == ST_CLEAR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_CLEAR;
            count <= '0;
        end else begin
            state <= next_state;
            count <= next_count;
        end
    end

    always_comb begin
        next_state = state;
        next_count = count;
        clear_we   = 1'b0;
        case (state)
            ST_CLEAR: begin
                clear_we   = 1'b1;
                next_count = count + 1'b1;
                if (count == IDX_W'(DEPTH - 1)) next_state = ST_READY;
            end
            default: ;
        endcase
    end

    // The clear sweep and stores share one masked write port; they never overlap.
    always_comb begin
        store_we  = ready & bus.we & ~w_error;
        mem_we    = ~rst & (clear_we | store_we);
        mem_idx   = clear_we ? count : w_idx;
        mem_mask  = clear_we ? 4'b1111 : lane_mask(bus.w_size, bus.wr_addr[1:0]);
        mem_wdata = clear_we ? '0 : store_lanes(bus.w_size, bus.data_in);
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (mem_mask[i]) mem[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
        end
    end

    assign r_word = mem[r_idx];

    dmem_load_align u_align (
        .word        (r_word),
        .lane        (bus.r_addr[1:0]),
        .size        (bus.r_size),
        .is_unsigned (bus.r_unsigned),
        .data        (aligned)
    );

    // Reading here, in the same edge as a write, returns the pre-write word.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.data_out <= '0;
            bus.r_valid  <= 1'b0;
            bus.r_err    <= 1'b0;
            bus.w_err    <= 1'b0;
        end else begin
            bus.w_err <= ready & bus.we & w_error;
            if (ready && bus.re) begin
                bus.r_valid  <= 1'b1;
                bus.r_err    <= r_error;
                bus.data_out <= r_error ? '0 : aligned;
            end else begin
                bus.r_valid <= 1'b0;
                bus.r_err   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_be.sv
// Directed bench for data_mem_be with a queue of expected load results.
module tb_data_mem_be;
    import dmem_pkg::*;

    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 32;

    typedef struct {
        string       tag;
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_mem_be_if #(.ADDR_W(ADDR_W)) bus ();

    data_mem_be #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] m_word;
    logic [1:0]  m_lane;
    logic [1:0]  m_size;
    logic        m_uns;
    logic [31:0] m_data;

    dmem_load_align u_model (
        .word        (m_word),
        .lane        (m_lane),
        .size        (m_size),
        .is_unsigned (m_uns),
        .data        (m_data)
    );

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic collect();
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({e.tag, "_valid"}, {31'b0, bus.r_valid}, 32'd1);
            check({e.tag, "_err"}, {31'b0, bus.r_err}, {31'b0, e.err});
            check({e.tag, "_data"}, bus.data_out, e.data);
        end
    endtask

    task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic err, input logic [31:0] data);
        bus.re         = 1'b1;
        bus.r_addr     = addr;
        bus.r_size     = size;
        bus.r_unsigned = uns;
        sb.push_back('{tag, err, data});
        step();
        bus.re = 1'b0;
        collect();
    endtask

    task automatic do_store(input string tag, input logic [31:0] addr, input logic [1:0] size,
                            input logic [31:0] data, input logic err);
        bus.we      = 1'b1;
        bus.wr_addr = addr;
        bus.w_size  = size;
        bus.data_in = data;
        step();
        bus.we = 1'b0;
        check({tag, "_werr"}, {31'b0, bus.w_err}, {31'b0, err});
        step();
        check({tag, "_werr_drop"}, {31'b0, bus.w_err}, 32'd0);
    endtask

    task automatic wait_ready(input string tag, input int exp_cycles);
        int n = 0;
        while (bus.busy && n < 3000) begin
            step();
            n++;
        end
        check(tag, 32'(n), 32'(exp_cycles));
    endtask

    initial begin
        int viol;
        bus.re = 1'b0; bus.r_addr = '0; bus.r_size = 2'b00; bus.r_unsigned = 1'b0;
        bus.we = 1'b0; bus.wr_addr = '0; bus.w_size = 2'b00; bus.data_in = '0;
        m_word = '0; m_lane = '0; m_size = '0; m_uns = 1'b0;

        // reset state and clear duration
        step();
        step();
        check("rst_busy", {31'b0, bus.busy}, 32'd1);
        check("rst_rvalid", {31'b0, bus.r_valid}, 32'd0);
        check("rst_rerr", {31'b0, bus.r_err}, 32'd0);
        check("rst_werr", {31'b0, bus.w_err}, 32'd0);
        check("rst_dout", bus.data_out, 32'h0);
        rst = 1'b0;
        wait_ready("clear_cycles", DEPTH);
        do_load("lw_3fc", 32'h3FC, SZ_WORD, 1'b0, 1'b0, 32'h0000_0000);

        // byte store/load
        do_store("sw_100", 32'h100, SZ_WORD, 32'h1122_3344, 1'b0);
        do_store("sb_102", 32'h102, SZ_BYTE, 32'h0000_0080, 1'b0);
        do_load("lw_100", 32'h100, SZ_WORD, 1'b0, 1'b0, 32'h1180_3344);
        do_load("lb_102", 32'h102, SZ_BYTE, 1'b0, 1'b0, 32'hFFFF_FF80);
        do_load("lbu_102", 32'h102, SZ_BYTE, 1'b1, 1'b0, 32'h0000_0080);
        step();
        check("hold_rvalid", {31'b0, bus.r_valid}, 32'd0);
        check("hold_dout", bus.data_out, 32'h0000_0080);

        // halfword
        do_store("sw_204", 32'h204, SZ_WORD, 32'h1234_5678, 1'b0);
        do_store("sh_206", 32'h206, SZ_HALF, 32'h0000_BEEF, 1'b0);
        do_load("lh_206", 32'h206, SZ_HALF, 1'b0, 1'b0, 32'hFFFF_BEEF);
        do_load("lhu_206", 32'h206, SZ_HALF, 1'b1, 1'b0, 32'h0000_BEEF);
        do_load("lhu_204", 32'h204, SZ_HALF, 1'b1, 1'b0, 32'h0000_5678);
        do_load("lw_204", 32'h204, SZ_WORD, 1'b0, 1'b0, 32'hBEEF_5678);

        // error handling
        do_store("sw_101", 32'h101, SZ_WORD, 32'hFFFF_FFFF, 1'b1);
        do_load("lw_100_after_bad_sw", 32'h100, SZ_WORD, 1'b0, 1'b0, 32'h1180_3344);
        do_load("lw_1000", 32'h1000, SZ_WORD, 1'b0, 1'b1, 32'h0);
        do_load("l_size11", 32'h100, SZ_BAD, 1'b0, 1'b1, 32'h0);
        do_load("lh_101", 32'h101, SZ_HALF, 1'b0, 1'b1, 32'h0);
        do_store("s_size11", 32'h100, SZ_BAD, 32'hFFFF_FFFF, 1'b1);
        do_store("sh_1002", 32'h1002, SZ_HALF, 32'h0000_FFFF, 1'b1);
        do_store("sb_fffc", 32'hFFFF_FFFC, SZ_BYTE, 32'h0000_00FF, 1'b1);
        do_load("lw_100_after_bad", 32'h100, SZ_WORD, 1'b0, 1'b0, 32'h1180_3344);

        // same-word read and write in one cycle
        do_store("sw_40", 32'h40, SZ_WORD, 32'hA5A5_A5A5, 1'b0);
        bus.we = 1'b1; bus.wr_addr = 32'h40; bus.w_size = SZ_WORD; bus.data_in = 32'h5A5A_5A5A;
        bus.re = 1'b1; bus.r_addr = 32'h40; bus.r_size = SZ_WORD; bus.r_unsigned = 1'b0;
        sb.push_back('{"rw_same_old", 1'b0, 32'hA5A5_A5A5});
        step();
        bus.we = 1'b0;
        bus.re = 1'b0;
        collect();
        do_load("rw_same_new", 32'h40, SZ_WORD, 1'b0, 1'b0, 32'h5A5A_5A5A);

        // lane/size sweep against a shadow word
        do_store("sw_300", 32'h300, SZ_WORD, 32'h8877_F155, 1'b0);
        do_load("lb_301", 32'h301, SZ_BYTE, 1'b0, 1'b0, 32'hFFFF_FFF1);
        m_word = 32'h8877_F155;
        for (int unsigned l = 0; l < 4; l++) begin
            for (int unsigned s = 0; s < 2; s++) begin
                for (int unsigned u = 0; u < 2; u++) begin
                    if (!(s == 1 && l[0])) begin
                        m_lane = l[1:0];
                        m_size = s[1:0];
                        m_uns  = u[0];
                        #1;
                        do_load("sweep", 32'h300 + l, s[1:0], u[0], 1'b0, m_data);
                    end
                end
            end
        end

        // reset during operation with a load in flight, then mid-clear restart
        rst = 1'b1;
        bus.re = 1'b1; bus.r_addr = 32'h40; bus.r_size = SZ_WORD; bus.r_unsigned = 1'b0;
        step();
        bus.re = 1'b0;
        rst = 1'b0;
        check("rst_inflight_rvalid", {31'b0, bus.r_valid}, 32'd0);
        check("rst_inflight_dout", bus.data_out, 32'h0);
        check("rst_inflight_busy", {31'b0, bus.busy}, 32'd1);
        for (int unsigned i = 0; i < 500; i++) step();
        check("busy_at_500", {31'b0, bus.busy}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.we = 1'b1; bus.wr_addr = 32'h10; bus.w_size = SZ_WORD; bus.data_in = 32'hDEAD_BEEF;
        bus.re = 1'b1; bus.r_addr = 32'h10; bus.r_size = SZ_WORD;
        viol = 0;
        begin
            int n = 0;
            while (bus.busy && n < 3000) begin
                step();
                n++;
                if (bus.r_valid || bus.w_err) viol++;
            end
            bus.we = 1'b0;
            bus.re = 1'b0;
            check("restart_clear_cycles", 32'(n), 32'(DEPTH));
        end
        check("busy_ignored_cycles", 32'(viol), 32'd0);
        do_load("lw_10_after_busy", 32'h10, SZ_WORD, 1'b0, 1'b0, 32'h0);
        do_load("lw_100_cleared", 32'h100, SZ_WORD, 1'b0, 1'b0, 32'h0);
        do_load("lw_40_cleared", 32'h40, SZ_WORD, 1'b0, 1'b0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/data_mem_be.md
DATA_MEM_BE -- requirements
Module: data_mem_be

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, number of 32-bit words (power of two, >=4).
REQ-002 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports re input 1 read enable; r_addr input ADDR_W read byte address; r_size input 2 read access size; r_unsigned input 1 zero-extend loads.
REQ-006 SHALL have ports we input 1 write enable; wr_addr input ADDR_W write byte address; w_size input 2 write access size; data_in input 32 store data (right-justified).
REQ-007 SHALL have outputs data_out 32 registered load data; r_valid 1 load result valid; r_err 1 load error; w_err 1 store error pulse; busy 1 clear-in-progress.

Function
REQ-008 SHALL encode size as 00 byte, 01 halfword, 10 word; 11 illegal.
REQ-009 SHALL use byte addressing, little-endian lanes; word index = addr[log2(DEPTH)+1:2], lane = addr[1:0].
REQ-010 SHALL flag an access as error if: size 11; halfword with addr[0]=1; word with addr[1:0]!=00; addr >= 4*DEPTH.
REQ-011 SHALL, for an accepted non-error store, write only the addressed lanes (byte: data_in[7:0] to lane addr[1:0]; half: data_in[15:0] to lanes addr[1]*2..+1; word: all four), other lanes unchanged.
REQ-012 SHALL, for an erroneous store, leave memory unchanged and assert w_err for exactly one cycle after the request edge.
REQ-013 SHALL give loads 1-cycle latency: request sampled at edge N, data_out/r_valid valid after edge N, r_valid high exactly one cycle per request.
REQ-014 SHALL extract the addressed byte/half and sign-extend from bit 7/15, or zero-extend when r_unsigned=1; word loads unchanged.
REQ-015 SHALL, for an erroneous load, assert r_valid and r_err with data_out=0.
REQ-016 SHALL hold data_out at its last value when r_valid=0.
REQ-017 SHALL return pre-write (old) data when read and write target the same word in the same cycle.
REQ-018 SHALL implement FSM CLEAR/READY: rst forces CLEAR with counter 0; in CLEAR with rst low, write 0 to word[counter], increment; after word DEPTH-1 go to READY.
REQ-019 SHALL assert busy in CLEAR (including while rst high); busy deasserts exactly DEPTH cycles after rst falls.
REQ-020 SHALL ignore re/we while busy: no memory update, r_valid=0, w_err=0.
REQ-021 SHALL restart the clear from word 0 if rst asserts mid-clear or mid-operation; in-flight load result discarded (r_valid=0).

Reset
REQ-022 SHALL on rst drive data_out=0, r_valid=0, r_err=0, w_err=0, busy=1, state CLEAR, counter 0.
REQ-023 SHALL guarantee all words read 0 once busy falls; no per-cycle array-wide reset loop.

Structure
REQ-024 SHALL place size encodings (SZ_BYTE/SZ_HALF/SZ_WORD) and FSM state encodings in shared package dmem_pkg.
REQ-025 SHALL use one sub-module, dmem_load_align (combinational lane select + extension), reused by the bench model.
REQ-026 SHALL infer the array as a single-write-port, registered-read RAM; byte enables via lane masks.

Verification
REQ-027 SHALL test reset: pulse rst 1 cycle -> busy high 1024 cycles, then low; read word 0x3FC -> data_out=0x00000000, r_err=0.
REQ-028 SHALL test byte store/load: word 0x100 <- 0x11223344, sb 0x80 to 0x102 -> lw 0x100 = 0x11803344; lb 0x102 = 0xFFFFFF80; lbu 0x102 = 0x00000080.
REQ-029 SHALL test halfword: sh 0xBEEF to 0x206 -> lh 0x206 = 0xFFFFBEEF; lhu = 0x0000BEEF; lanes 0x204-0x205 unchanged.
REQ-030 SHALL test errors: sw to 0x101 -> w_err 1 cycle, memory unchanged; lw 0x1000 -> r_valid=1, r_err=1, data_out=0; size 11 -> error.
REQ-031 SHALL test same-word read/write: word 0x40=0xA5A5A5A5, sw 0x5A5A5A5A and lw 0x40 same cycle -> data_out=0xA5A5A5A5; next lw -> 0x5A5A5A5A.
REQ-032 SHALL test rst at clear counter 500 -> counter restarts, busy low exactly 1024 cycles after rst falls; re/we during busy -> r_valid=0, no write.
